// File: rtl/antares_divider.sv
// antares_divider: iterative 32/32 integer divider for MIPS DIV/DIVU.
// One restoring radix-2 step per clock: load edge, 32 iteration edges and a
// sign-fix edge, so a result appears 34 edges after the start edge.
// Quotient feeds LO and remainder feeds HI. The hazard unit stalls MFHI/MFLO
// while div_active is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   div_dividend        dividend (rs)
//   div_divisor         divisor (rt)
//   div_start_signed    start a DIV (wins if both start bits are set)
//   div_start_unsigned  start a DIVU
//   flush               abort the operation in flight; results are kept
//   div_quotient        quotient (LO), held until the next result
//   div_remainder       remainder (HI), held until the next result
//   div_active          operation in progress
//   div_ready           one-cycle pulse when a fresh result is on the outputs
module antares_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] div_dividend,
  input  logic [31:0] div_divisor,
  input  logic        div_start_signed,
  input  logic        div_start_unsigned,
  input  logic        flush,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder,
  output logic        div_active,
  output logic        div_ready
);

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [31:0]        rem_q;    // partial remainder, always < |b| (or |a| on div0)
  logic [31:0]        quo_q;    // dividend shifts out the top, quotient bits in the bottom
  logic [31:0]        bmag_q;
  logic [31:0]        a_raw;
  logic               q_neg, r_neg, div0;

  // Magnitude in 33 bits so that -0x80000000 becomes +0x80000000.
  function automatic logic [32:0] mag33(input logic [31:0] x, input logic neg);
    mag33 = neg ? (33'd0 - {1'b1, x}) : {1'b0, x};
  endfunction

  logic        start_go;
  logic        op_signed;
  logic        sign_a, sign_b;
  logic [32:0] amag, bmag;
  logic [32:0] shifted;
  logic        take;
  logic [31:0] diff;

  assign start_go  = (state == S_IDLE) && (div_start_signed || div_start_unsigned) && !flush;
  assign op_signed = div_start_signed;
  assign sign_a    = op_signed & div_dividend[31];
  assign sign_b    = op_signed & div_divisor[31];
  assign amag      = mag33(div_dividend, sign_a);
  assign bmag      = mag33(div_divisor, sign_b);

  // Restoring step: shift {rem, quo} left and subtract |b| when it fits.
  // The difference always fits 32 bits because the shifted value < 2*|b|.
  assign shifted = {rem_q, quo_q[31]};
  assign take    = (shifted >= {1'b0, bmag_q});
  assign diff    = shifted[31:0] - bmag_q;

  assign div_active = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_go) state_nxt = S_BUSY;
      S_BUSY: if (count == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      bmag_q        <= '0;
      a_raw         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      div0          <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_ready     <= 1'b0;
    end else begin
      div_ready <= 1'b0;
      if (start_go) begin
        quo_q  <= amag[31:0];
        bmag_q <= bmag[31:0];
        a_raw  <= div_dividend;
        rem_q  <= '0;
        q_neg  <= sign_a ^ sign_b;
        r_neg  <= sign_a;
        div0   <= (div_divisor == '0);
        count  <= CNT_W'(DIV_STEPS - 1);
      end else if (state == S_BUSY && !flush) begin
        rem_q <= take ? diff : shifted[31:0];
        quo_q <= {quo_q[30:0], take};
        count <= count - 1'b1;
      end else if (state == S_FIX && !flush) begin
        // Divide-by-zero follows the MIPS convention regardless of signedness.
        div_quotient  <= div0 ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quo_q) : quo_q);
        div_remainder <= div0 ? a_raw : (r_neg ? (32'd0 - rem_q) : rem_q);
        div_ready     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/antares_divider.md
Name: antares_divider

Overview:
- Iterative 32/32 integer divider for the MIPS DIV/DIVU instructions, one restoring radix-2 step per clock.
- It is the inverse-operation companion to the pipelined multiplier and sits beside it in the EX stage.
- It delivers the quotient to LO and the remainder to HI.
- The hazard unit reads div_active to stall MFHI/MFLO until the result is ready.

Parameters:
- none; the 32-bit datapath is fixed by the ISA. Internal constants are localparams.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- div_dividend  input  32  dividend operand (rs)
- div_divisor  input  32  divisor operand (rt)
- div_start_signed  input  1  start a DIV
- div_start_unsigned  input  1  start a DIVU
- flush  input  1  abort the operation in flight (exception/branch squash)
- div_quotient  output  32  quotient, goes to LO
- div_remainder  output  32  remainder, goes to HI
- div_active  output  1  an operation is in progress
- div_ready  output  1  one-cycle pulse: outputs hold a fresh result

Behaviour:
- Reset:
  - div_quotient=0, div_remainder=0, div_active=0, div_ready=0.
  - Internal state: IDLE, count=0.
- States: IDLE and BUSY, plus a FIX step taken at count expiry.
- Start:
  - A start is accepted on an edge where state is IDLE (div_active=0) and either start bit is high.
  - If both start bits are high, signed wins.
  - A start is accepted while div_ready is high; div_ready drops on the next edge.
  - A start presented while BUSY is ignored, with no queueing.
- Load edge (E0):
  - Capture op_signed.
  - Capture the magnitudes |a| and |b|. Negate an operand only if signed and its bit 31 is set; use 33-bit arithmetic so that 0x80000000 is handled.
  - Capture q_neg = sign_a ^ sign_b, r_neg = sign_a, and div0 = (divisor==0).
  - Set partial remainder=0, count=31, div_active=1.
- Iteration edges E1..E32:
  - Compute {rem, quo} shifted left by 1 and trial = rem - |b| (33 bits).
  - If trial is non-negative: rem=trial and the quotient LSB is 1. Otherwise rem is unchanged and the LSB is 0.
  - count decrements; the step at count==0 is the last.
- FIX edge E33:
  - div_quotient = q_neg ? -quo : quo.
  - div_remainder = r_neg ? -rem : rem.
  - If div0: force div_quotient=0xFFFFFFFF and div_remainder=raw dividend, regardless of signedness.
  - div_active=0, div_ready=1 for exactly one cycle, state goes to IDLE.
- Latency:
  - The result is visible and div_ready is high in the cycle after the 34th edge counted from the start edge (E0..E33).
  - div_active is high from the cycle after E0 through the cycle ending at E33.
- Holding: outputs keep their values until the next FIX edge or reset. A flush does not clear them.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Remainder sign: follows the dividend (truncating division). A zero remainder is never negated to a nonzero value.
- Flush:
  - Flush while BUSY: state goes to IDLE, div_active=0 and div_ready=0 on the next edge, outputs unchanged.
  - Flush on a start edge: flush wins and the start is dropped.
  - Flush in the div_ready cycle clears div_ready on the next edge only (the result stays).
- rst mid-operation: full reset, same as the reset state above.

Decomposition:
- No shared package is needed.
- Localparams: DIV_STEPS=32, a 5-bit count width, and the state encodings.
- Single module, no sub-module. Magnitude/negate helpers are local functions.

Test Plan:
- DIVU 100/7:
  - quotient=14, remainder=2.
  - div_ready high exactly one cycle, 34 edges after the start edge.
  - div_active high for 33 cycles.
- DIV -7/2 gives q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7/-2 gives q=0xFFFFFFFD, r=1. DIV -8/-2 gives q=4, r=0.
- DIV 0x80000000/0xFFFFFFFF gives q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 gives q=0xFFFFFFFF, r=0.
- Divide by zero:
  - DIVU 0x1234/0 gives q=0xFFFFFFFF, r=0x1234.
  - DIV 0xFFFFFFFB/0 gives q=0xFFFFFFFF, r=0xFFFFFFFB.
  - Both take the normal latency.
- Flush 10 cycles into DIVU 50/5:
  - div_active=0 next cycle, div_ready never pulses, outputs retain the prior result.
  - A following DIVU 9/4 yields q=2, r=1.
- Rejected and colliding starts:
  - A start while BUSY (new operands 1/1) is ignored; the original 100/7 completes with q=14, r=2.
  - Start with flush on the same edge: no operation begins.
  - Both start bits with -9/2 gives a signed result q=0xFFFFFFFC, r=0xFFFFFFFF.
